scurve_data_packer: RTL and testbench

- Upstream neighbour of the S-curve data FIFO.
- Takes one result per DAC step (channel, DAC code, trigger count, hit count) from the S-curve test controller and serialises it into 16-bit words for the FIFO.
- Adds a scan header word and a scan tail word around each scan, so the USB readout can frame the data.
- Drives the FIFO din/wr_en inputs and stalls on FIFO full.

---
 rtl/scurve_data_packer_if.sv | 43 ++++
 rtl/scurve_data_packer.sv | 123 ++++++++++++
 tb/tb_scurve_data_packer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/scurve_data_packer_if.sv
// Handshake bundle between the S-curve controller, the data packer and the data FIFO.
// The slave modport is the packer's view; the master modport drives the packer.
interface scurve_data_packer_if;
  logic        scan_start;
  logic        scan_done;
  logic        result_valid;
  logic        result_ready;
  logic [5:0]  channel;
  logic [9:0]  dac_code;
  logic [15:0] trig_count;
  logic [15:0] hit_count;
  logic        fifo_full;
  logic [15:0] fifo_din;
  logic        fifo_wr_en;

  modport slave (
    input  scan_start,
    input  scan_done,
    input  result_valid,
    output result_ready,
    input  channel,
    input  dac_code,
    input  trig_count,
    input  hit_count,
    input  fifo_full,
    output fifo_din,
    output fifo_wr_en
  );

  modport master (
    output scan_start,
    output scan_done,
    output result_valid,
    input  result_ready,
    output channel,
    output dac_code,
    output trig_count,
    output hit_count,
    output fifo_full,
    input  fifo_din,
    input  fifo_wr_en
  );
endinterface

// File: rtl/scurve_data_packer.sv
// Serialises S-curve results into 16-bit FIFO words, framed by scan header/tail words.
// A result becomes three words: {channel, dac_code}, trig_count, hit_count.
module scurve_data_packer #(
  parameter logic [15:0] HEADER_WORD = 16'hFF45,
  parameter logic [15:0] TAIL_WORD   = 16'hFF54
) (
  input  logic                        clk,
  input  logic                        rst_n,
  scurve_data_packer_if.slave         bus,
  output logic                        busy,
  output logic [15:0]                 point_cnt,
  output logic                        drop_err
);

  typedef enum logic [2:0] {StIdle, StHead, StWId, StWTrig, StWHit, StTail} state_e;

  state_e      state_q, state_d;
  logic        start_pend_q, start_pend_d;
  logic        done_pend_q, done_pend_d;
  logic        ready_q, ready_d;
  logic        drop_q, drop_d;
  logic [15:0] din_q, din_d;
  logic [15:0] point_q, point_d;
  logic [15:0] trig_q, trig_d;
  logic [15:0] hit_q, hit_d;
  logic        wr;

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q | bus.scan_start;
    done_pend_d  = done_pend_q | bus.scan_done;
    din_d        = din_q;
    point_d      = point_q;
    trig_d       = trig_q;
    hit_d        = hit_q;
    wr           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_pend_q) begin
          state_d      = StHead;
          start_pend_d = bus.scan_start;
          din_d        = HEADER_WORD;
        end else if (bus.result_valid && ready_q) begin
          state_d = StWId;
          din_d   = {bus.channel, bus.dac_code};
          trig_d  = bus.trig_count;
          hit_d   = bus.hit_count;
          point_d = point_q + 16'd1;
        end else if (done_pend_q) begin
          state_d     = StTail;
          done_pend_d = bus.scan_done;
          din_d       = TAIL_WORD;
        end
      end
      StHead: begin
        if (!bus.fifo_full) begin
          wr      = 1'b1;
          point_d = 16'd0;
          state_d = StIdle;
        end
      end
      StWId: begin
        if (!bus.fifo_full) begin
          wr      = 1'b1;
          din_d   = trig_q;
          state_d = StWTrig;
        end
      end
      StWTrig: begin
        if (!bus.fifo_full) begin
          wr      = 1'b1;
          din_d   = hit_q;
          state_d = StWHit;
        end
      end
      StWHit, StTail: begin
        if (!bus.fifo_full) begin
          wr      = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Ready is registered, so any pulse seen this cycle blocks acceptance next cycle.
    ready_d = (state_d == StIdle) && !start_pend_d && !done_pend_d;
    drop_d  = drop_q | (bus.result_valid & ~ready_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      start_pend_q <= 1'b0;
      done_pend_q  <= 1'b0;
      ready_q      <= 1'b0;
      drop_q       <= 1'b0;
      din_q        <= 16'd0;
      point_q      <= 16'd0;
      trig_q       <= 16'd0;
      hit_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      done_pend_q  <= done_pend_d;
      ready_q      <= ready_d;
      drop_q       <= drop_d;
      din_q        <= din_d;
      point_q      <= point_d;
      trig_q       <= trig_d;
      hit_q        <= hit_d;
    end
  end

  // Gated by rst_n so a packet being abandoned cannot write during the reset cycle.
  assign bus.fifo_wr_en   = wr & rst_n;
  assign bus.fifo_din     = din_q;
  assign bus.result_ready = ready_q;
  assign busy             = (state_q != StIdle) | start_pend_q | done_pend_q;
  assign point_cnt        = point_q;
  assign drop_err         = drop_q;

endmodule

// File: tb/tb_scurve_data_packer.sv
// Directed bench for scurve_data_packer: a queue of expected FIFO words is filled as
// stimulus is driven and drained as the packer writes.
module tb_scurve_data_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] point_cnt;
  logic        drop_err;

  always #5 clk = ~clk;

  scurve_data_packer_if bus();

  scurve_data_packer #(
    .HEADER_WORD(16'hFF45),
    .TAIL_WORD  (16'hFF54)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .point_cnt(point_cnt),
    .drop_err (drop_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pts = 16'd0;
  logic        exp_drop = 1'b0;
  logic [15:0] w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (bus.fifo_wr_en === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("fifo_word", 32'(bus.fifo_din), 32'(w));
        if (w == 16'hFF45) exp_pts = 16'd0;
      end
    end
    if (!rst_n) begin
      exp_pts  = 16'd0;
      exp_drop = 1'b0;
    end else if (bus.result_valid === 1'b1) begin
      if (bus.result_ready === 1'b1) begin
        exp_q.push_back({bus.channel, bus.dac_code});
        exp_q.push_back(bus.trig_count);
        exp_q.push_back(bus.hit_count);
        exp_pts = exp_pts + 16'd1;
      end else begin
        exp_drop = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic start, input logic done);
    bus.scan_start = start;
    bus.scan_done  = done;
    if (start) exp_q.push_back(16'hFF45);
    if (done)  exp_q.push_back(16'hFF54);
    tick();
    bus.scan_start = 1'b0;
    bus.scan_done  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!busy && bus.result_ready === 1'b1) break;
      tick();
    end
    chk(tag, 32'(bus.result_ready), 32'd1);
  endtask

  task automatic set_fields(input logic [5:0] ch, input logic [9:0] dac,
                            input logic [15:0] trig, input logic [15:0] hit);
    bus.channel    = ch;
    bus.dac_code   = dac;
    bus.trig_count = trig;
    bus.hit_count  = hit;
  endtask

  task automatic send_result(input logic [5:0] ch, input logic [9:0] dac,
                             input logic [15:0] trig, input logic [15:0] hit);
    wait_idle("ready_before_send");
    set_fields(ch, dac, trig, hit);
    bus.result_valid = 1'b1;
    tick();
    bus.result_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 32'(bus.result_ready), 32'd0);
    chk("rst_din", 32'(bus.fifo_din), 32'd0);
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_point_cnt", 32'(point_cnt), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
  endtask

  initial begin
    bus.scan_start   = 1'b0;
    bus.scan_done    = 1'b0;
    bus.result_valid = 1'b0;
    bus.fifo_full    = 1'b0;
    set_fields(6'd0, 10'd0, 16'd0, 16'd0);

    // 1: reset, scan framing around a single result
    tick();
    tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 32'(bus.result_ready), 32'd1);
    pulse(1'b1, 1'b0);
    wait_idle("t1_after_header");
    send_result(6'd5, 10'd300, 16'd1000, 16'd512);
    wait_idle("t1_after_packet");
    chk("t1_point_cnt", 32'(point_cnt), 32'd1);
    pulse(1'b0, 1'b1);
    wait_idle("t1_after_tail");
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_drop_err", 32'(drop_err), 32'(exp_drop));
    chk("t1_drop_err_clear", 32'(drop_err), 32'd0);

    // 2: FIFO stall in W_TRIG for three cycles
    set_fields(6'd5, 10'd300, 16'd1000, 16'd512);
    bus.result_valid = 1'b1;
    tick();
    bus.result_valid = 1'b0;
    #1;
    chk("t2_n1_wr", 32'(bus.fifo_wr_en), 32'd1);
    chk("t2_n1_din", 32'(bus.fifo_din), 32'h152C);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.fifo_full = 1'b1;
      #1;
      chk("t2_stall_wr", 32'(bus.fifo_wr_en), 32'd0);
      chk("t2_stall_din", 32'(bus.fifo_din), 32'h03E8);
      tick();
    end
    bus.fifo_full = 1'b0;
    #1;
    chk("t2_n5_wr", 32'(bus.fifo_wr_en), 32'd1);
    chk("t2_n5_din", 32'(bus.fifo_din), 32'h03E8);
    tick();
    chk("t2_n6_wr", 32'(bus.fifo_wr_en), 32'd1);
    chk("t2_n6_din", 32'(bus.fifo_din), 32'h0200);
    chk("t2_n6_ready", 32'(bus.result_ready), 32'd0);
    tick();
    chk("t2_n7_ready", 32'(bus.result_ready), 32'd1);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: valid held high across three back-to-back results
    wait_idle("t3_start");
    set_fields(6'd1, 10'd17, 16'h0101, 16'h0011);
    bus.result_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      set_fields(6'(k + 2), 10'(k * 100 + 33), 16'(16'h1000 + k), 16'(16'h0200 + k));
      for (int j = 0; j < 3; j++) begin
        chk("t3_ready_low_packing", 32'(bus.result_ready), 32'd0);
        tick();
      end
      chk("t3_ready_back", 32'(bus.result_ready), 32'd1);
    end
    bus.result_valid = 1'b0;
    wait_idle("t3_end");
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_drop_err", 32'(drop_err), 32'd1);
    chk("t3_point_cnt", 32'(point_cnt), 32'(exp_pts));

    // 4: simultaneous scan_start and scan_done in IDLE
    pulse(1'b1, 1'b1);
    wait_idle("t4_end");
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t4_point_cnt", 32'(point_cnt), 32'd0);

    // 5: reset asserted while in W_TRIG abandons the packet
    send_result(6'd10, 10'h3FF, 16'hAAAA, 16'h5555);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_no_write_in_reset", 32'(bus.fifo_wr_en), 32'd0);
    tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    tick();
    send_result(6'd63, 10'd1, 16'hBEEF, 16'h1234);
    #1;
    chk("t5_fresh_id_word", 32'(bus.fifo_din), 32'hFC01);
    wait_idle("t5_end");
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t5_point_cnt", 32'(point_cnt), 32'd1);
    chk("t5_drop_err", 32'(drop_err), 32'(exp_drop));

    // 6: scan_start during W_ID waits for the packet, then clears point_cnt
    send_result(6'd7, 10'd512, 16'd42, 16'd21);
    pulse(1'b1, 1'b0);
    chk("t6_busy", 32'(busy), 32'd1);
    wait_idle("t6_end");
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_point_cnt", 32'(point_cnt), 32'(exp_pts));
    chk("t6_point_zero", 32'(point_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
